// File: rtl/rotation_profile.sv
// rotation_profile
// Turns the shortest-path delta stream into a ramped steering-motor command.
// It requests delta calculations and latches every result. The wheel then
// moves through accelerate, cruise and decelerate phases until the remaining
// delta is within tolerance. A progress watchdog flags a stalled wheel.
//
// Ports:
//   clock, reset_n  : main clock, asynchronous active-low reset
//   start_rotation  : one-cycle pulse, begins a move (honoured in IDLE only)
//   abort           : level, forces IDLE with the drive off (highest priority)
//   delta_angle     : shortest distance reported by the calculator
//   dir_shortest    : 1 = CCW, 0 = CW
//   calc_updated    : one-cycle pulse, delta_angle/dir_shortest are valid
//   enable_calc     : requests continuous calculation while a move is active
//   pwm_duty        : duty command to the PWM generator
//   pwm_dir         : direction command
//   pwm_enable      : motor drive enable
//   rotation_busy   : high in every state except IDLE and FAULT
//   rotation_done   : one-cycle completion pulse
//   stall_fault     : sticky stall flag, cleared only by abort
module rotation_profile #(
    parameter logic [7:0]  DUTY_MIN     = 8'd20,
    parameter logic [7:0]  DUTY_MAX     = 8'd200,
    parameter int          RAMP_DIV     = 16,
    parameter logic [11:0] DECEL_ZONE   = 12'd200,
    parameter logic [11:0] TOL          = 12'd8,
    parameter logic [23:0] STALL_CYCLES = 24'd5_000_000
) (
    input  logic        reset_n,
    input  logic        clock,
    input  logic        start_rotation,
    input  logic        abort,
    input  logic [11:0] delta_angle,
    input  logic        dir_shortest,
    input  logic        calc_updated,
    output logic        enable_calc,
    output logic [7:0]  pwm_duty,
    output logic        pwm_dir,
    output logic        pwm_enable,
    output logic        rotation_busy,
    output logic        rotation_done,
    output logic        stall_fault
);

    localparam int DIV_W = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_CALC = 3'd1,
        S_ACCEL     = 3'd2,
        S_CRUISE    = 3'd3,
        S_DECEL     = 3'd4,
        S_DONE      = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [11:0]      delta_q_r;
    logic             dir_q_r;
    logic             upd_r;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_s;
    logic [23:0]      wd_r;
    logic [23:0]      wd_s;
    logic [23:0]      wd_inc_s;
    logic [7:0]       duty_s;
    logic             dir_s;
    logic             drive_s;
    logic             tick_s;
    logic             progress_s;
    logic             active_s;
    logic             moving_s;

    // States in which the calculator runs and the watchdog counts
    function automatic logic calc_state(input state_t s);
        return (s == S_WAIT_CALC) || (s == S_ACCEL) ||
               (s == S_CRUISE)    || (s == S_DECEL);
    endfunction

    // Next-state, duty profile and watchdog decisions
    always_comb begin
        state_s    = state_r;
        duty_s     = pwm_duty;
        dir_s      = pwm_dir;
        drive_s    = pwm_enable;
        div_s      = div_r;
        wd_s       = wd_r;
        wd_inc_s   = wd_r + 24'd1;
        tick_s     = (div_r == DIV_LAST);
        // Progress is judged against the previously latched delta, so it is
        // evaluated on the pulse itself rather than one cycle later.
        progress_s = calc_updated && (delta_angle < delta_q_r);
        active_s   = calc_state(state_r);
        moving_s   = (state_r == S_ACCEL) || (state_r == S_CRUISE) ||
                     (state_r == S_DECEL);

        if (abort) begin
            state_s = S_IDLE;
            duty_s  = 8'd0;
            drive_s = 1'b0;
            div_s   = DIV_ZERO;
            wd_s    = 24'd0;
        end else if (active_s && !progress_s && (wd_inc_s >= STALL_CYCLES)) begin
            state_s = S_FAULT;
            duty_s  = 8'd0;
            drive_s = 1'b0;
            div_s   = DIV_ZERO;
            wd_s    = 24'd0;
        end else begin
            if (active_s) begin
                wd_s = progress_s ? 24'd0 : wd_inc_s;
            end else begin
                wd_s = 24'd0;
            end
            div_s = tick_s ? DIV_ZERO : (div_r + DIV_ONE);

            // A fresh result pointing the other way means the wheel overshot:
            // reverse at minimum duty and decelerate into the target.
            if (moving_s && upd_r && (dir_q_r != pwm_dir)) begin
                dir_s = dir_q_r;
                if (delta_q_r <= TOL) begin
                    state_s = S_DONE;
                    duty_s  = 8'd0;
                    drive_s = 1'b0;
                end else begin
                    state_s = S_DECEL;
                    duty_s  = DUTY_MIN;
                    div_s   = DIV_ZERO;
                end
            end else begin
                case (state_r)
                    S_IDLE: begin
                        duty_s  = 8'd0;
                        drive_s = 1'b0;
                        if (start_rotation) begin
                            state_s = S_WAIT_CALC;
                        end else begin
                            state_s = S_IDLE;
                        end
                    end
                    S_WAIT_CALC: begin
                        if (upd_r) begin
                            if (delta_q_r <= TOL) begin
                                state_s = S_DONE;
                                duty_s  = 8'd0;
                                drive_s = 1'b0;
                            end else begin
                                state_s = S_ACCEL;
                                duty_s  = DUTY_MIN;
                                dir_s   = dir_q_r;
                                drive_s = 1'b1;
                                div_s   = DIV_ZERO;
                            end
                        end else begin
                            state_s = S_WAIT_CALC;
                        end
                    end
                    S_ACCEL: begin
                        // Zone entry beats a coincident ramp step.
                        if (delta_q_r < DECEL_ZONE) begin
                            state_s = S_DECEL;
                            div_s   = DIV_ZERO;
                        end else if (tick_s) begin
                            if (pwm_duty >= (DUTY_MAX - 8'd1)) begin
                                duty_s  = DUTY_MAX;
                                state_s = S_CRUISE;
                            end else begin
                                duty_s = pwm_duty + 8'd1;
                            end
                        end else if (pwm_duty >= DUTY_MAX) begin
                            duty_s  = DUTY_MAX;
                            state_s = S_CRUISE;
                        end else begin
                            state_s = S_ACCEL;
                        end
                    end
                    S_CRUISE: begin
                        duty_s = DUTY_MAX;
                        if (delta_q_r < DECEL_ZONE) begin
                            state_s = S_DECEL;
                            div_s   = DIV_ZERO;
                        end else begin
                            state_s = S_CRUISE;
                        end
                    end
                    S_DECEL: begin
                        if (delta_q_r <= TOL) begin
                            state_s = S_DONE;
                            duty_s  = 8'd0;
                            drive_s = 1'b0;
                        end else if (tick_s) begin
                            duty_s = (pwm_duty > DUTY_MIN) ? (pwm_duty - 8'd1) : DUTY_MIN;
                        end else begin
                            state_s = S_DECEL;
                        end
                    end
                    S_DONE: begin
                        state_s = S_IDLE;
                        duty_s  = 8'd0;
                        drive_s = 1'b0;
                    end
                    S_FAULT: begin
                        state_s = S_FAULT;
                        duty_s  = 8'd0;
                        drive_s = 1'b0;
                    end
                    default: begin
                        state_s = S_IDLE;
                        duty_s  = 8'd0;
                        drive_s = 1'b0;
                    end
                endcase
            end
        end
    end

    // State, latched calculator result, counters and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= S_IDLE;
            delta_q_r     <= 12'hFFF;
            dir_q_r       <= 1'b0;
            upd_r         <= 1'b0;
            div_r         <= DIV_ZERO;
            wd_r          <= 24'd0;
            pwm_duty      <= 8'd0;
            pwm_dir       <= 1'b0;
            pwm_enable    <= 1'b0;
            enable_calc   <= 1'b0;
            rotation_busy <= 1'b0;
            rotation_done <= 1'b0;
            stall_fault   <= 1'b0;
        end else begin
            state_r <= state_s;
            div_r   <= div_s;
            wd_r    <= wd_s;
            upd_r   <= calc_updated;
            if (calc_updated) begin
                delta_q_r <= delta_angle;
                dir_q_r   <= dir_shortest;
            end
            pwm_duty      <= duty_s;
            pwm_dir       <= dir_s;
            pwm_enable    <= drive_s;
            enable_calc   <= calc_state(state_s);
            rotation_busy <= (state_s != S_IDLE) && (state_s != S_FAULT);
            rotation_done <= (state_s == S_DONE);
            stall_fault   <= (state_s == S_FAULT);
        end
    end

endmodule

// File: tb/tb_rotation_profile.sv
// Self-checking bench for rotation_profile. A phase-level reference model
// computes the duty profile from elapsed cycles in each ramp phase and is
// stepped in lockstep with the DUT; directed scenarios add spot checks
// against constant expectations.
module tb_rotation_profile;

    localparam int DMIN  = 20;
    localparam int DMAX  = 24;
    localparam int DIV   = 4;
    localparam int ZONE  = 100;
    localparam int TOLV  = 8;
    localparam int STALL = 64;

    localparam int MP_IDLE   = 0;
    localparam int MP_WAIT   = 1;
    localparam int MP_ACCEL  = 2;
    localparam int MP_CRUISE = 3;
    localparam int MP_DECEL  = 4;
    localparam int MP_DONE   = 5;
    localparam int MP_FAULT  = 6;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start_rotation;
    logic        abort;
    logic [11:0] delta_angle;
    logic        dir_shortest;
    logic        calc_updated;
    logic        enable_calc;
    logic [7:0]  pwm_duty;
    logic        pwm_dir;
    logic        pwm_enable;
    logic        rotation_busy;
    logic        rotation_done;
    logic        stall_fault;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int   m_phase;
    int   m_duty;
    logic m_dir;
    int   m_wd;
    int   m_cyc;
    int   m_base;
    logic m_upd;
    int   m_dq;
    logic m_dirq;

    always #5 clock = ~clock;

    rotation_profile #(
        .DUTY_MIN     (8'd20),
        .DUTY_MAX     (8'd24),
        .RAMP_DIV     (4),
        .DECEL_ZONE   (12'd100),
        .TOL          (12'd8),
        .STALL_CYCLES (24'd64)
    ) dut (
        .reset_n        (reset_n),
        .clock          (clock),
        .start_rotation (start_rotation),
        .abort          (abort),
        .delta_angle    (delta_angle),
        .dir_shortest   (dir_shortest),
        .calc_updated   (calc_updated),
        .enable_calc    (enable_calc),
        .pwm_duty       (pwm_duty),
        .pwm_dir        (pwm_dir),
        .pwm_enable     (pwm_enable),
        .rotation_busy  (rotation_busy),
        .rotation_done  (rotation_done),
        .stall_fault    (stall_fault)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) begin
                $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
            end
        end
    endtask

    task automatic model_reset();
        m_phase = MP_IDLE;
        m_duty  = 0;
        m_dir   = 1'b0;
        m_wd    = 0;
        m_cyc   = 0;
        m_base  = 0;
        m_upd   = 1'b0;
        m_dq    = 4095;
        m_dirq  = 1'b0;
    endtask

    // One clock of the behavioural model, given the inputs sampled at the edge.
    task automatic model_step(input logic st, input logic ab, input logic cu,
                              input int d, input logic dr);
        logic progress;
        logic active;
        logic moving;
        progress = cu && (d < m_dq);
        active   = (m_phase >= MP_WAIT) && (m_phase <= MP_DECEL);
        moving   = (m_phase >= MP_ACCEL) && (m_phase <= MP_DECEL);
        if (ab) begin
            m_phase = MP_IDLE;
            m_duty  = 0;
            m_wd    = 0;
        end else if (active && !progress && (m_wd + 1 >= STALL)) begin
            m_phase = MP_FAULT;
            m_duty  = 0;
            m_wd    = 0;
        end else begin
            m_wd = (active && !progress) ? m_wd + 1 : 0;
            if (moving && m_upd && (m_dirq != m_dir)) begin
                m_dir = m_dirq;
                if (m_dq <= TOLV) begin
                    m_phase = MP_DONE;
                    m_duty  = 0;
                end else begin
                    m_phase = MP_DECEL;
                    m_duty  = DMIN;
                    m_base  = DMIN;
                    m_cyc   = 0;
                end
            end else begin
                case (m_phase)
                    MP_IDLE: if (st) m_phase = MP_WAIT;
                    MP_WAIT: begin
                        if (m_upd) begin
                            if (m_dq <= TOLV) begin
                                m_phase = MP_DONE;
                            end else begin
                                m_phase = MP_ACCEL;
                                m_duty  = DMIN;
                                m_dir   = m_dirq;
                                m_cyc   = 0;
                            end
                        end
                    end
                    MP_ACCEL: begin
                        if (m_dq < ZONE) begin
                            m_phase = MP_DECEL;
                            m_base  = m_duty;
                            m_cyc   = 0;
                        end else begin
                            m_cyc++;
                            m_duty = DMIN + m_cyc / DIV;
                            if (m_duty >= DMAX) begin
                                m_duty  = DMAX;
                                m_phase = MP_CRUISE;
                            end
                        end
                    end
                    MP_CRUISE: begin
                        if (m_dq < ZONE) begin
                            m_phase = MP_DECEL;
                            m_base  = DMAX;
                            m_cyc   = 0;
                        end
                    end
                    MP_DECEL: begin
                        if (m_dq <= TOLV) begin
                            m_phase = MP_DONE;
                            m_duty  = 0;
                        end else begin
                            m_cyc++;
                            m_duty = m_base - m_cyc / DIV;
                            if (m_duty < DMIN) m_duty = DMIN;
                        end
                    end
                    MP_DONE:  m_phase = MP_IDLE;
                    default:  m_phase = m_phase;
                endcase
            end
        end
        m_upd = cu;
        if (cu) begin
            m_dq   = d;
            m_dirq = dr;
        end
    endtask

    task automatic compare_all();
        check_eq("duty",  pwm_duty, m_duty);
        check_eq("dir",   pwm_dir, m_dir);
        check_eq("drive", pwm_enable, (m_phase >= MP_ACCEL) && (m_phase <= MP_DECEL));
        check_eq("calc",  enable_calc, (m_phase >= MP_WAIT) && (m_phase <= MP_DECEL));
        check_eq("busy",  rotation_busy, (m_phase != MP_IDLE) && (m_phase != MP_FAULT));
        check_eq("done",  rotation_done, m_phase == MP_DONE);
        check_eq("stall", stall_fault, m_phase == MP_FAULT);
    endtask

    task automatic cycle(input logic st, input logic ab, input logic cu,
                         input int d, input logic dr);
        @(negedge clock);
        start_rotation = st;
        abort          = ab;
        calc_updated   = cu;
        delta_angle    = 12'(d);
        dir_shortest   = dr;
        @(posedge clock);
        model_step(st, ab, cu, d, dr);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_duty"},  pwm_duty, 0);
        check_eq({tag, "_dir"},   pwm_dir, 0);
        check_eq({tag, "_drive"}, pwm_enable, 0);
        check_eq({tag, "_calc"},  enable_calc, 0);
        check_eq({tag, "_busy"},  rotation_busy, 0);
        check_eq({tag, "_done"},  rotation_done, 0);
        check_eq({tag, "_stall"}, stall_fault, 0);
    endtask

    initial begin
        int cur_delta;
        int step_v;
        logic st;
        logic ab;
        logic cu;
        logic dr;

        reset_n        = 1'b0;
        start_rotation = 1'b0;
        abort          = 1'b0;
        calc_updated   = 1'b0;
        delta_angle    = 12'd0;
        dir_shortest   = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;

        // full move
        cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
        check_eq("fm_wait_calc", enable_calc, 1);
        check_eq("fm_wait_drive", pwm_enable, 0);
        cycle(1'b0, 1'b0, 1'b1, 500, 1'b1);
        idle(1);
        check_eq("fm_accel_duty", pwm_duty, 20);
        check_eq("fm_accel_dir", pwm_dir, 1);
        check_eq("fm_accel_drive", pwm_enable, 1);
        idle(15);
        check_eq("fm_accel_duty23", pwm_duty, 23);
        idle(1);
        check_eq("fm_cruise_duty", pwm_duty, 24);
        cycle(1'b0, 1'b0, 1'b1, 300, 1'b1);
        idle(3);
        check_eq("fm_cruise_hold", pwm_duty, 24);
        cycle(1'b0, 1'b0, 1'b1, 90, 1'b1);
        idle(1);
        idle(16);
        check_eq("fm_decel_floor", pwm_duty, 20);
        idle(2);
        check_eq("fm_decel_sat", pwm_duty, 20);
        cycle(1'b0, 1'b0, 1'b1, 5, 1'b1);
        idle(1);
        check_eq("fm_done_pulse", rotation_done, 1);
        check_eq("fm_done_drive", pwm_enable, 0);
        check_eq("fm_done_calc", enable_calc, 0);
        idle(1);
        check_eq("fm_done_once", rotation_done, 0);

        // already aligned
        cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 3, 1'b0);
        check_eq("al_drive0", pwm_enable, 0);
        idle(1);
        check_eq("al_done", rotation_done, 1);
        check_eq("al_drive1", pwm_enable, 0);
        idle(1);

        // overshoot from cruise
        cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 500, 1'b1);
        idle(17);
        check_eq("os_cruise", pwm_duty, 24);
        cycle(1'b0, 1'b0, 1'b1, 40, 1'b0);
        idle(1);
        check_eq("os_dir", pwm_dir, 0);
        check_eq("os_duty", pwm_duty, 20);
        check_eq("os_drive", pwm_enable, 1);
        cycle(1'b0, 1'b0, 1'b1, 5, 1'b0);
        idle(1);
        check_eq("os_done", rotation_done, 1);
        idle(1);

        // stall
        cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 500, 1'b1);
        for (int k = 0; k < 8; k++) begin
            idle(9);
            cycle(1'b0, 1'b0, 1'b1, 500, 1'b1);
        end
        check_eq("st_fault", stall_fault, 1);
        check_eq("st_busy", rotation_busy, 0);
        check_eq("st_drive", pwm_enable, 0);
        check_eq("st_duty", pwm_duty, 0);
        cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
        check_eq("st_start_ignored", stall_fault, 1);
        cycle(1'b0, 1'b1, 1'b0, 0, 1'b0);
        check_eq("st_abort_clear", stall_fault, 0);
        check_eq("st_abort_busy", rotation_busy, 0);
        idle(1);

        // abort mid-accel at duty 22, then abort together with start
        cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 500, 1'b1);
        idle(9);
        check_eq("ab_duty22", pwm_duty, 22);
        cycle(1'b0, 1'b1, 1'b0, 0, 1'b0);
        check_eq("ab_duty", pwm_duty, 0);
        check_eq("ab_drive", pwm_enable, 0);
        check_eq("ab_calc", enable_calc, 0);
        check_eq("ab_nodone", rotation_done, 0);
        cycle(1'b1, 1'b1, 1'b0, 0, 1'b0);
        check_eq("ab_start_busy", rotation_busy, 0);
        idle(2);
        check_eq("ab_stay_idle", rotation_busy, 0);

        // reset mid-cruise
        cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 500, 1'b1);
        idle(20);
        check_eq("rs_cruise", pwm_duty, 24);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_eq("rs_async_duty", pwm_duty, 0);
        check_eq("rs_async_drive", pwm_enable, 0);
        check_eq("rs_async_busy", rotation_busy, 0);
        check_eq("rs_async_calc", enable_calc, 0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b1, 50, 1'b1);
        idle(2);
        check_eq("rs_idle_busy", rotation_busy, 0);
        check_eq("rs_idle_drive", pwm_enable, 0);

        // randomized soak against the model
        cur_delta = 800;
        dr = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            st = ($urandom_range(0, 99) < 6);
            ab = ($urandom_range(0, 299) < 2);
            cu = ($urandom_range(0, 99) < 15);
            if (st) cur_delta = int'($urandom_range(0, 1500));
            if (cu) begin
                step_v = int'($urandom_range(0, 40));
                if (step_v > cur_delta) step_v = cur_delta;
                cur_delta = cur_delta - step_v;
                if ($urandom_range(0, 9) == 0) dr = ~dr;
            end
            cycle(st, ab, cu, cur_delta, dr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
